// File: rtl/alu_pkg.sv
// Shared opcode definitions for the pipelined ALU.
package alu_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_ADD4    = 3'd0,
        OP_SUB     = 3'd1,
        OP_AND     = 3'd2,
        OP_OR      = 3'd3,
        OP_XOR     = 3'd4,
        OP_NOT     = 3'd5,
        OP_SEL_SUM = 3'd6,
        OP_ACC     = 3'd7
    } op_e;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU datapath: result, carry/borrow and zero flag.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  op_e              opcode,
    input  logic             sel,
    input  logic [WIDTH-1:0] acc,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero
);

    logic [WIDTH+1:0] sum4;
    logic [WIDTH:0]   ext;

    // Four-operand sum keeps two guard bits so any overflow is visible.
    assign sum4 = {2'b00, a} + {2'b00, b} + {2'b00, c} + {2'b00, d};

    // Operation select; two-operand sums share one WIDTH+1 bit intermediate.
    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        result = '0;
        carry  = 1'b0;
        ext    = '0;
        case (opcode)
            OP_ADD4: begin
                result = sum4[WIDTH-1:0];
                carry  = |sum4[WIDTH+1:WIDTH];
            end
            OP_SUB: begin
                // Zero-extended subtraction: bit WIDTH is set exactly when a < b.
                ext    = {1'b0, a} - {1'b0, b};
                result = ext[WIDTH-1:0];
                carry  = ext[WIDTH];
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_NOT: result = ~a;
            OP_SEL_SUM: begin
                ext    = sel ? ({1'b0, a} + {1'b0, c}) : ({1'b0, b} + {1'b0, d});
                result = ext[WIDTH-1:0];
                carry  = ext[WIDTH];
            end
            OP_ACC: begin
                ext    = sel ? {1'b0, a} : ({1'b0, acc} + {1'b0, a});
                result = ext[WIDTH-1:0];
                carry  = sel ? 1'b0 : ext[WIDTH];
            end
            default: begin
                result = '0;
                carry  = 1'b0;
            end
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU pipeline: S1 holds operands, S2 holds result/flags.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] input_a,
    input  logic [WIDTH-1:0] input_b,
    input  logic [WIDTH-1:0] input_c,
    input  logic [WIDTH-1:0] input_d,
    input  logic [OP_W-1:0]  opcode,
    input  logic             sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero_flag,
    output logic             carry_flag
);

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d, s1_c_q, s1_c_d, s1_d_q, s1_d_d;
    op_e              s1_op_q, s1_op_d;
    logic             s1_sel_q, s1_sel_d;

    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] s2_result_q, s2_result_d;
    logic             s2_zero_q, s2_zero_d;
    logic             s2_carry_q, s2_carry_d;

    logic [WIDTH-1:0] acc_q, acc_d;

    logic             s2_load;
    logic             in_fire;
    logic [WIDTH-1:0] core_result;
    logic             core_carry;
    logic             core_zero;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .a      (s1_a_q),
        .b      (s1_b_q),
        .c      (s1_c_q),
        .d      (s1_d_q),
        .opcode (s1_op_q),
        .sel    (s1_sel_q),
        .acc    (acc_q),
        .result (core_result),
        .carry  (core_carry),
        .zero   (core_zero)
    );

    // Handshake and next-state: S2 drains or refills, S1 follows; acc moves with ACC ops into S2.
    always_comb begin
        s2_load     = s1_valid_q && (!s2_valid_q || out_ready);
        in_ready    = !s1_valid_q || s2_load;
        in_fire     = in_valid && in_ready;

        s1_valid_d  = in_fire || (s1_valid_q && !s2_load);
        s1_a_d      = in_fire ? input_a : s1_a_q;
        s1_b_d      = in_fire ? input_b : s1_b_q;
        s1_c_d      = in_fire ? input_c : s1_c_q;
        s1_d_d      = in_fire ? input_d : s1_d_q;
        s1_op_d     = in_fire ? op_e'(opcode) : s1_op_q;
        s1_sel_d    = in_fire ? sel : s1_sel_q;

        s2_valid_d  = s2_load || (s2_valid_q && !out_ready);
        s2_result_d = s2_load ? core_result : s2_result_q;
        s2_zero_d   = s2_load ? core_zero   : s2_zero_q;
        s2_carry_d  = s2_load ? core_carry  : s2_carry_q;

        acc_d       = (s2_load && (s1_op_q == OP_ACC)) ? core_result : acc_q;
    end

    // Control, output and accumulator state with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_result_q <= '0;
            s2_zero_q   <= 1'b1;
            s2_carry_q  <= 1'b0;
            acc_q       <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so all flops sample pre-edge values.
            s1_valid_q  <= s1_valid_d;
            s2_valid_q  <= s2_valid_d;
            s2_result_q <= s2_result_d;
            s2_zero_q   <= s2_zero_d;
            s2_carry_q  <= s2_carry_d;
            acc_q       <= acc_d;
        end
    end

    // S1 operand payload; only meaningful while s1_valid_q is set.
    // NOTE: payload registers are deliberately reset-less; the valid bit guards them.
    always_ff @(posedge clk) begin
        s1_a_q   <= s1_a_d;
        s1_b_q   <= s1_b_d;
        s1_c_q   <= s1_c_d;
        s1_d_q   <= s1_d_d;
        s1_op_q  <= s1_op_d;
        s1_sel_q <= s1_sel_d;
    end

    assign out_valid  = s2_valid_q;
    assign result     = s2_result_q;
    assign zero_flag  = s2_zero_q;
    assign carry_flag = s2_carry_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe (WIDTH=8): vector table, corner sequences, random stream.
module tb_alu_pipe;

    localparam int W = 8;
    localparam int M = 1 << W;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] input_a = '0, input_b = '0, input_c = '0, input_d = '0;
    logic [2:0]   opcode = '0;
    logic         sel = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] result;
    logic         zero_flag, carry_flag;

    alu_pipe #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .input_a    (input_a),
        .input_b    (input_b),
        .input_c    (input_c),
        .input_d    (input_d),
        .opcode     (opcode),
        .sel        (sel),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .zero_flag  (zero_flag),
        .carry_flag (carry_flag)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] res;
        logic         z;
        logic         cy;
    } exp_t;

    typedef struct {
        logic [2:0]   op;
        logic         sel;
        logic [W-1:0] a, b, c, d;
        logic [W-1:0] res;
        logic         z, cy;
    } vec_t;

    exp_t         sb_q[$];
    logic [W-1:0] seen_q[$];
    int           checks = 0, failures = 0, n_in = 0, n_out = 0;
    int           model_acc = 0;
    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_res;
    logic         prev_z, prev_c;
    vec_t         vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model from the operation rules using plain integer arithmetic.
    function automatic exp_t model(input logic [2:0] op, input logic s,
                                   input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [W-1:0] c, input logic [W-1:0] d);
        int   ia = int'(a), ib = int'(b), ic = int'(c), id = int'(d), sum = 0, r = 0;
        logic cy = 1'b0;
        exp_t e;
        case (op)
            3'd0: begin sum = ia + ib + ic + id; r = sum % M; cy = (sum >= M); end
            3'd1: begin r = (ia - ib + M) % M; cy = (ia < ib); end
            3'd2: r = ia & ib;
            3'd3: r = ia | ib;
            3'd4: r = ia ^ ib;
            3'd5: r = (M - 1) - ia;
            3'd6: begin sum = s ? ia + ic : ib + id; r = sum % M; cy = (sum >= M); end
            default: begin
                if (s) begin
                    model_acc = ia;
                end else begin
                    sum = model_acc + ia;
                    model_acc = sum % M;
                    cy = (sum >= M);
                end
                r = model_acc;
            end
        endcase
        e.res = W'(r);
        e.z   = (r == 0);
        e.cy  = cy;
        return e;
    endfunction

    // Called at a negedge after inputs are driven: scoreboard both handshakes, then advance a cycle.
    task automatic tick();
        exp_t e;
        #1;
        if (prev_stall) begin
            check("hold_valid", out_valid, 1);
            check("hold_result", result, prev_res);
            check("hold_flags", {zero_flag, carry_flag}, {prev_z, prev_c});
        end
        if (in_valid && in_ready) begin
            sb_q.push_back(model(opcode, sel, input_a, input_b, input_c, input_d));
            n_in++;
        end
        if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_output", 1, 0);
            end else begin
                e = sb_q.pop_front();
                check("sb_result", result, e.res);
                check("sb_zero", zero_flag, e.z);
                check("sb_carry", carry_flag, e.cy);
            end
            seen_q.push_back(result);
            n_out++;
        end
        prev_stall = out_valid && !out_ready;
        prev_res   = result;
        prev_z     = zero_flag;
        prev_c     = carry_flag;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic [2:0] op, input logic s, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] c, input logic [W-1:0] d);
        in_valid = 1'b1;
        opcode   = op;
        sel      = s;
        input_a  = a;
        input_b  = b;
        input_c  = c;
        input_d  = d;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_result"}, result, 0);
        check({tag, "_zero"}, zero_flag, 1);
        check({tag, "_carry"}, carry_flag, 0);
        check({tag, "_acc"}, dut.acc_q, 0);
        check({tag, "_in_ready"}, in_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        //            op    sel   a      b      c      d      res    z     cy
        vecs[0]  = '{3'd0, 1'b0, 8'h40, 8'h40, 8'h40, 8'h40, 8'h00, 1'b1, 1'b1};
        vecs[1]  = '{3'd1, 1'b0, 8'h05, 8'h07, 8'h00, 8'h00, 8'hFE, 1'b0, 1'b1};
        vecs[2]  = '{3'd6, 1'b0, 8'h11, 8'h80, 8'h22, 8'h80, 8'h00, 1'b1, 1'b1};
        vecs[3]  = '{3'd6, 1'b1, 8'h12, 8'hFF, 8'h34, 8'hFF, 8'h46, 1'b0, 1'b0};
        vecs[4]  = '{3'd2, 1'b0, 8'hF0, 8'h3C, 8'h00, 8'h00, 8'h30, 1'b0, 1'b0};
        vecs[5]  = '{3'd3, 1'b0, 8'h0F, 8'hF0, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b0};
        vecs[6]  = '{3'd4, 1'b0, 8'hAA, 8'hAA, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0};
        vecs[7]  = '{3'd5, 1'b0, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0};
        vecs[8]  = '{3'd5, 1'b0, 8'h5A, 8'h00, 8'h00, 8'h00, 8'hA5, 1'b0, 1'b0};
        vecs[9]  = '{3'd1, 1'b0, 8'h07, 8'h05, 8'h00, 8'h00, 8'h02, 1'b0, 1'b0};
        vecs[10] = '{3'd0, 1'b0, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A, 1'b0, 1'b0};
        vecs[11] = '{3'd0, 1'b0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFC, 1'b0, 1'b1};
        vecs[12] = '{3'd7, 1'b1, 8'h10, 8'h00, 8'h00, 8'h00, 8'h10, 1'b0, 1'b0};
        vecs[13] = '{3'd7, 1'b0, 8'hF8, 8'h00, 8'h00, 8'h00, 8'h08, 1'b0, 1'b1};

        // Reset values, asserted asynchronously between clock edges.
        #2 rst_n = 1'b0;
        #1 check_reset_state("rst");
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("rst_release_in_ready", in_ready, 1);
        @(negedge clk);

        // Table vectors, one at a time, with latency check.
        out_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].op, vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].d);
            tick();
            in_valid = 1'b0;
            check($sformatf("vec%0d_not_early", i), out_valid, 0);
            tick();
            check($sformatf("vec%0d_valid", i), out_valid, 1);
            check($sformatf("vec%0d_result", i), result, vecs[i].res);
            check($sformatf("vec%0d_zero", i), zero_flag, vecs[i].z);
            check($sformatf("vec%0d_carry", i), carry_flag, vecs[i].cy);
        end
        tick();
        tick();

        // Back-to-back ACC: load then accumulate in consecutive cycles.
        drive(3'd7, 1'b1, 8'h10, 8'h00, 8'h00, 8'h00);
        tick();
        drive(3'd7, 1'b0, 8'hF8, 8'h00, 8'h00, 8'h00);
        tick();
        in_valid = 1'b0;
        check("b2b_acc1_result", result, 8'h10);
        check("b2b_acc1_carry", carry_flag, 0);
        tick();
        check("b2b_acc2_valid", out_valid, 1);
        check("b2b_acc2_result", result, 8'h08);
        check("b2b_acc2_carry", carry_flag, 1);
        check("b2b_acc2_zero", zero_flag, 0);
        tick();
        tick();

        // Backpressure: two ops fill the pipe, third waits, first result held.
        seen_q.delete();
        out_ready = 1'b0;
        drive(3'd4, 1'b0, 8'hAA, 8'h55, 8'h00, 8'h00);
        tick();
        drive(3'd2, 1'b0, 8'hF0, 8'h0F, 8'h00, 8'h00);
        #1 check("bp_ready_second", in_ready, 1);
        tick();
        drive(3'd3, 1'b0, 8'h01, 8'h02, 8'h00, 8'h00);
        #1 check("bp_ready_full", in_ready, 0);
        for (int k = 0; k < 3; k++) begin
            check("bp_held_valid", out_valid, 1);
            check("bp_held_result", result, 8'hFF);
            check("bp_still_full", in_ready, 0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 10 && seen_q.size() < 3; k++) tick();
        check("bp_count", seen_q.size(), 3);
        if (seen_q.size() == 3) begin
            check("bp_order0", seen_q[0], 8'hFF);
            check("bp_order1", seen_q[1], 8'h00);
            check("bp_order2", seen_q[2], 8'h03);
        end
        tick();

        // Reset with both stages occupied discards everything.
        out_ready = 1'b0;
        drive(3'd7, 1'b1, 8'h55, 8'h00, 8'h00, 8'h00);
        tick();
        drive(3'd4, 1'b0, 8'h01, 8'h01, 8'h00, 8'h00);
        tick();
        in_valid = 1'b0;
        #1 check("full_out_valid", out_valid, 1);
        check("full_in_ready", in_ready, 0);
        rst_n = 1'b0;
        #1 check_reset_state("midrst");
        sb_q.delete();
        model_acc  = 0;
        prev_stall = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("midrst_release_in_ready", in_ready, 1);
        out_ready = 1'b1;
        drive(3'd7, 1'b0, 8'h03, 8'h00, 8'h00, 8'h00);
        tick();
        in_valid = 1'b0;
        tick();
        check("post_rst_valid", out_valid, 1);
        check("post_rst_acc_result", result, 8'h03);
        check("post_rst_acc_carry", carry_flag, 0);
        tick();
        tick();

        // Random stream against the model with random backpressure.
        n_in  = 0;
        n_out = 0;
        for (int k = 0; k < 600; k++) begin
            in_valid  = ($urandom_range(9) < 7);
            opcode    = 3'($urandom_range(7));
            sel       = 1'($urandom_range(1));
            input_a   = W'($urandom);
            input_b   = W'($urandom);
            input_c   = W'($urandom);
            input_d   = W'($urandom);
            out_ready = ($urandom_range(9) < 6);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) tick();
        check("rand_in_eq_out", n_out, n_in);
        check("rand_sb_empty", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
